// File: rtl/vfu_req_arbiter.sv
// Two-requester arbiter in front of one VFU port, with grant lock and an owner FIFO
// that routes in-order responses back; VFU_ARB_FIXED_PRIO_EN selects fixed priority (r0 wins).
module vfu_req_arbiter #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][DATA_W-1:0] req_insn,
  input  logic [1:0][DATA_W-1:0] req_data0,
  input  logic [1:0][DATA_W-1:0] req_data1,
  input  logic [1:0][ID_W-1:0]   req_id,
  output logic [1:0]             resp_valid,
  output logic [1:0][DATA_W-1:0] resp_data,
  output logic [1:0][ID_W-1:0]   resp_id,
  output logic                   vfu_req_valid,
  input  logic                   vfu_req_ready,
  output logic [DATA_W-1:0]      vfu_req_insn,
  output logic [DATA_W-1:0]      vfu_req_data0,
  output logic [DATA_W-1:0]      vfu_req_data1,
  output logic [ID_W-1:0]        vfu_req_id,
  input  logic                   vfu_resp_valid,
  input  logic [DATA_W-1:0]      vfu_resp_data,
  input  logic [ID_W-1:0]        vfu_resp_id,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                   err_orphan
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e            state_q, state_d;
  logic              lock_sel_q, lock_sel_d;
  logic              sel;
  logic              blocked;
  logic              accept;
  logic              pop;
  logic              orphan;
  logic              head;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]  owner_q;

`ifndef VFU_ARB_FIXED_PRIO_EN
  logic              last_q, last_d;
`endif

  // A locked grant overrides arbitration until its handshake completes.
  always_comb begin
    sel = 1'b0;
    if (state_q == ST_LOCKED) begin
      sel = lock_sel_q;
    end else begin
`ifdef VFU_ARB_FIXED_PRIO_EN
      sel = !req_valid[0] && req_valid[1];
`else
      if (&req_valid) begin
        sel = ~last_q;
      end else begin
        sel = req_valid[1];
      end
`endif
    end
  end

  // A response arriving this cycle frees a slot, so a full FIFO can still accept.
  assign blocked = (cnt_q == FULL_CNT) && !vfu_resp_valid;

  assign vfu_req_valid = rst_n && req_valid[sel] && !blocked;
  assign vfu_req_insn  = req_insn[sel];
  assign vfu_req_data0 = req_data0[sel];
  assign vfu_req_data1 = req_data1[sel];
  assign vfu_req_id    = req_id[sel];

  always_comb begin
    req_ready = 2'b00;
    if (rst_n && vfu_req_ready && !blocked) begin
      req_ready[sel] = 1'b1;
    end
  end

  assign accept = vfu_req_valid && vfu_req_ready;

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (vfu_req_valid && !vfu_req_ready) begin
          state_d    = ST_LOCKED;
          lock_sel_d = sel;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_sel_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

`ifndef VFU_ARB_FIXED_PRIO_EN
  assign last_d = accept ? sel : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign pop    = vfu_resp_valid && (cnt_q != '0);
  assign orphan = vfu_resp_valid && (cnt_q == '0);
  assign head   = owner_q[rd_ptr_q];

  always_comb begin
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    err_d    = err_q | orphan;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
    end
  end

  // Entries are only read behind a valid count, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      owner_q[wr_ptr_q] <= sel;
    end
  end

  always_comb begin
    resp_valid = 2'b00;
    if (rst_n && pop) begin
      resp_valid[head] = 1'b1;
    end
  end

  assign resp_data[0] = vfu_resp_data;
  assign resp_data[1] = vfu_resp_data;
  assign resp_id[0]   = vfu_resp_id;
  assign resp_id[1]   = vfu_resp_id;

  assign outstanding = cnt_q;
  assign err_orphan  = err_q;

endmodule
